// File: rtl/fetch_unit_pkg.sv
// fetch_pkg: shared definitions for the fetch unit and its branch target buffer.
//   ctr_t            2-bit saturating branch counter encoding
//   INSN_BYTES       fetch stride in bytes
//   DEFAULT_RESET_PC default PC loaded on reset
//   ctr_next()       saturating counter update
package fetch_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,  // strongly not taken
    CTR_WNT = 2'b01,  // weakly not taken
    CTR_WT  = 2'b10,  // weakly taken
    CTR_ST  = 2'b11   // strongly taken
  } ctr_t;

  localparam int unsigned INSN_BYTES       = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0100_0000;

  function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
    ctr_t n;
    n = ctr;
    if (taken) begin
      if (ctr != CTR_ST) n = ctr_t'(ctr + 2'b01);
    end else begin
      if (ctr != CTR_SNT) n = ctr_t'(ctr - 2'b01);
    end
    return n;
  endfunction

endpackage

// File: rtl/fetch_unit_btb.sv
// btb: direct-mapped branch target buffer with 2-bit saturating counters.
// All addresses are word addresses (byte address bits [XLEN-1:2]).
//   clock, reset      posedge clock, synchronous active-high reset
//   lookup_wpc        word PC being fetched
//   lookup_hit        valid entry with matching tag
//   lookup_taken      hit and counter predicts taken
//   lookup_target     stored word target of the indexed entry
//   update_valid      a resolved control instruction trains the table
//   update_wpc        word PC of the resolved instruction
//   update_target     resolved word target
//   update_taken      resolved direction
module btb
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BTB_ENTRIES = 16,
  parameter logic [1:0]  CTR_INIT    = 2'b01
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-3:0] lookup_wpc,
  output logic            lookup_hit,
  output logic            lookup_taken,
  output logic [XLEN-3:0] lookup_target,
  input  logic            update_valid,
  input  logic [XLEN-3:0] update_wpc,
  input  logic [XLEN-3:0] update_target,
  input  logic            update_taken
);

  localparam int unsigned IDX   = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = XLEN - 2 - IDX;

  logic             valid_q  [BTB_ENTRIES];
  logic [TAG_W-1:0] tag_q    [BTB_ENTRIES];
  logic [XLEN-3:0]  target_q [BTB_ENTRIES];
  ctr_t             ctr_q    [BTB_ENTRIES];

  logic [IDX-1:0]   l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             u_hit;

  assign l_idx = lookup_wpc[IDX-1:0];
  assign l_tag = lookup_wpc[XLEN-3:IDX];
  assign u_idx = update_wpc[IDX-1:0];
  assign u_tag = update_wpc[XLEN-3:IDX];

  // Lookup reads the registered table only, so a same-cycle update is not visible.
  always_comb begin
    lookup_hit    = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    lookup_taken  = lookup_hit && ctr_q[l_idx][1];
    lookup_target = target_q[l_idx];
    u_hit         = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= ctr_t'(CTR_INIT);
      end
    end else if (update_valid) begin
      if (u_hit) begin
        ctr_q[u_idx] <= ctr_next(ctr_q[u_idx], update_taken);
        if (update_taken) target_q[u_idx] <= update_target;
      end else if (update_taken) begin
        // Allocation overwrites whatever entry lives at this index.
        valid_q[u_idx]  <= 1'b1;
        tag_q[u_idx]    <= u_tag;
        target_q[u_idx] <= update_target;
        ctr_q[u_idx]    <= CTR_WT;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC generation with stall, execute redirect, flush and
// BTB-based next-PC prediction.
//   clock, reset        posedge clock, synchronous active-high reset
//   stall               hold pc_f
//   redirect_valid/pc   execute-stage correction, overrides stall
//   update_*            BTB training from the execute stage
//   pc_f                fetch PC to imemory (always word aligned)
//   pred_taken_f        prediction applied to pc_f
//   pred_target_f       predicted next PC (pc_f+4 when not taken)
//   flush               squash fetch/decode registers on redirect
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned      XLEN        = 32,
  parameter logic [XLEN-1:0]  RESET_PC    = XLEN'(DEFAULT_RESET_PC),
  parameter int unsigned      BTB_ENTRIES = 16,
  parameter logic [1:0]       CTR_INIT    = 2'b01
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            update_valid,
  input  logic [XLEN-1:0] update_pc,
  input  logic [XLEN-1:0] update_target,
  input  logic            update_taken,
  output logic [XLEN-1:0] pc_f,
  output logic            pred_taken_f,
  output logic [XLEN-1:0] pred_target_f,
  output logic            flush
);

  logic [XLEN-1:2] pc_q;
  logic [XLEN-1:0] pc_plus4;
  logic            btb_hit;
  logic            btb_taken;
  logic [XLEN-3:0] btb_target;
  logic            unused_bits;

  // Only the word address is stored, so pc_f[1:0] is structurally zero.
  assign pc_f     = {pc_q, 2'b00};
  assign pc_plus4 = pc_f + XLEN'(INSN_BYTES);

  btb #(
    .XLEN        (XLEN),
    .BTB_ENTRIES (BTB_ENTRIES),
    .CTR_INIT    (CTR_INIT)
  ) u_btb (
    .clock         (clock),
    .reset         (reset),
    .lookup_wpc    (pc_q),
    .lookup_hit    (btb_hit),
    .lookup_taken  (btb_taken),
    .lookup_target (btb_target),
    .update_valid  (update_valid),
    .update_wpc    (update_pc[XLEN-1:2]),
    .update_target (update_target[XLEN-1:2]),
    .update_taken  (update_taken)
  );

  // Prediction is masked during reset because the table still holds old training.
  assign pred_taken_f  = btb_taken && !reset;
  assign pred_target_f = pred_taken_f ? {btb_target, 2'b00} : pc_plus4;
  assign flush         = redirect_valid && !reset;

  assign unused_bits = ^{redirect_pc[1:0], update_pc[1:0], update_target[1:0], btb_hit};

  always_ff @(posedge clock) begin
    if (reset)               pc_q <= RESET_PC[XLEN-1:2];
    else if (redirect_valid) pc_q <= redirect_pc[XLEN-1:2];
    else if (!stall)         pc_q <= pred_target_f[XLEN-1:2];
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised successor to the single-cycle PC block (pc_0).
- Generates the fetch PC for imemory and supports stall, execute-stage redirect and flush.
- Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, so a fetched branch predicted taken steers the next PC without waiting for execute.
- Sits between the execute stage (resolution/update) and imemory (address).

Parameters:
- XLEN, 32, datapath/address width.
- RESET_PC, 32'h01000000, PC loaded on reset.
- BTB_ENTRIES, 16, number of BTB entries; power of two, at least 2.
- CTR_INIT, 2'b01, counter value loaded on reset.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold pc_f this cycle.
- redirect_valid  in  1  execute-stage correction (mispredict or jump).
- redirect_pc  in  XLEN  corrected next PC.
- update_valid  in  1  a control instruction resolved in execute.
- update_pc  in  XLEN  PC of the resolved instruction.
- update_target  in  XLEN  resolved target.
- update_taken  in  1  resolved direction.
- pc_f  out  XLEN  fetch PC, drives the imemory address.
- pred_taken_f  out  1  prediction applied to pc_f.
- pred_target_f  out  XLEN  predicted target for pc_f; equals pc_f+4 when pred_taken_f=0.
- flush  out  1  squash fetch/decode pipeline registers.

Behaviour:
- Reset (synchronous, active-high, one clock, clock named `clock`, reset named `reset`):
  - pc_f <= RESET_PC.
  - All BTB valid bits <= 0; all counters <= CTR_INIT.
  - Outputs during and after reset: pred_taken_f=0, pred_target_f=pc_f+4, flush=0.
  - Reset mid-operation discards all training.
- Alignment:
  - pc_f[1:0] is always 00.
  - redirect_pc[1:0] and update_target[1:0] are ignored (forced to 00).
- BTB addressing:
  - IDX = log2(BTB_ENTRIES).
  - index = pc[IDX+1:2]; tag = pc[XLEN-1:IDX+2].
  - Each entry holds: valid, tag, target[XLEN-1:2], ctr[1:0].
- Lookup (combinational on pc_f):
  - hit = valid && tag match.
  - pred_taken_f = hit && ctr[1].
  - pred_target_f = pred_taken_f ? target : pc_f+4.
- Next-PC priority at posedge (highest first):
  1. reset → RESET_PC.
  2. redirect_valid → redirect_pc. Redirect overrides stall.
  3. stall → hold pc_f.
  4. otherwise → pred_target_f.
- flush:
  - Combinational; flush = redirect_valid && !reset.
  - Asserted in the same cycle as the redirect, so downstream registers clear on the same edge that loads redirect_pc.
- PC arithmetic:
  - Modulo 2^XLEN.
  - pc_f+4 at the top of the address space wraps to 0 with no error.
- BTB update (posedge, when update_valid && !reset):
  - Hit, taken: ctr saturating increment (11 stays 11); target <= update_target.
  - Hit, not taken: ctr saturating decrement (00 stays 00); target unchanged.
  - Miss, taken: allocate (overwrite). valid=1, tag, target, ctr=2'b10.
  - Miss, not taken: no change.
- Simultaneous events:
  - Update and lookup to the same index in one cycle: the lookup sees pre-update contents. No write-through bypass.
  - update_valid with stall: the update still occurs.
  - update_valid with redirect: both take effect.
- Counter encoding: 00 strongly-not-taken, 01 weakly-not-taken, 10 weakly-taken, 11 strongly-taken.
- Latency:
  - Prediction: 0 cycles (same cycle as pc_f).
  - Redirect: 1 cycle (pc_f = redirect_pc after the next edge).
  - Training visible: the cycle after the update edge.

Decomposition:
- Package fetch_pkg holds:
  - Counter encodings CTR_SNT/CTR_WNT/CTR_WT/CTR_ST.
  - INSN_BYTES=4.
  - Default RESET_PC.
  - Function ctr_next(ctr, taken) for saturating update.
- Sub-module btb:
  - Storage arrays, lookup port (pc → hit, taken, target) and update port.
  - Parametrised by XLEN and BTB_ENTRIES.
- fetch_unit owns the PC register, next-PC mux and flush generation.

Test Plan:
1. Reset held 2 cycles, then released → pc_f sequence 0x01000000, 0x01000004, 0x01000008; pred_taken_f=0; flush=0.
2. Stall high 3 cycles at 0x01000008 → pc_f holds. Then redirect_valid with 0x01000100 while stall=1 → flush=1 that cycle, pc_f=0x01000100 next cycle.
3. Update (pc 0x01000010, target 0x01000040, taken) → when fetch reaches 0x01000010: pred_taken_f=1, pred_target_f=0x01000040, next pc_f=0x01000040.
4. Two not-taken updates on 0x01000010 → ctr 10→01→00, pred_taken_f=0. A third not-taken stays 00. Two taken updates → 10, prediction taken again.
5. BTB_ENTRIES=16, entry trained at 0x01000010. Fetch 0x01000050 (same index, different tag) → miss, predicts 0x01000054. Taken update for 0x01000050 → replaces the entry, and 0x01000010 now misses.
6. Trained BTB, then reset pulsed for 1 cycle → pc_f=0x01000000; all predictions not-taken. Same-cycle update/lookup collision returns the old entry.
